fetch_unit: RTL and testbench

Instruction fetch stage directly downstream of the program counter register. Takes the current PC, issues a single-outstanding request to instruction memory, and buffers returned instructions with their PCs in a small queue drained by decode over a valid/ready handshake. Tells the program counter when it may advance, and discards queued or in-flight fetches on a pipeline flush.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_queue.sv | 62 ++++++
 rtl/fetch_unit.sv | 137 +++++++++++++
 tb/tb_fetch_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = '0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    WAIT_RESP,
    DROP
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            fault;
  } entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Parameterised circular FIFO with push, pop and flush; flush wins over push/pop.
// The head reads as zero while the queue is empty.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 65,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);
  assign head    = (count != '0) ? mem[rd_ptr] : '0;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count gates the head so stale words never escape.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding imem request, PC-tagged instruction queue to decode.
// Optional FETCH_MISALIGN_TRAP_EN turns misaligned PCs into fault entries instead of fetches.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  output logic            pc_advance,
  input  logic            flush,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            if_ready
`ifdef FETCH_MISALIGN_TRAP_EN
  , output logic          if_fault
`endif
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

  state_t          state, next_state;
  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   count;
  logic            push;
  entry_t          push_entry;
  entry_t          head;
  logic            issue;
  logic            can_fetch;
  logic            fault_fetch;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic stalled;

  assign can_fetch   = !stalled && (pc_in[1:0] == 2'b00);
  assign fault_fetch = !stalled && (pc_in[1:0] != 2'b00);
  assign if_fault    = head.fault;

  // A fault entry freezes fetching until execute redirects the PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         stalled <= 1'b0;
    else if (flush)                  stalled <= 1'b0;
    else if (state == IDLE && push)  stalled <= 1'b1;
  end
`else
  logic unused_fault;

  assign can_fetch    = 1'b1;
  assign fault_fetch  = 1'b0;
  assign unused_fault = head.fault;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    next_state       = state;
    issue            = 1'b0;
    push             = 1'b0;
    push_entry.pc    = fetch_pc;
    push_entry.instr = imem_rdata;
    push_entry.fault = 1'b0;
    case (state)
      IDLE: begin
        // Issuing only below QDEPTH reserves the slot the response will land in.
        if (!flush && (count < QFULL)) begin
          if (fault_fetch) begin
            push       = 1'b1;
            push_entry = '{pc: pc_in, instr: NOP_INSTR, fault: 1'b1};
          end else if (can_fetch) begin
            issue      = 1'b1;
            next_state = WAIT_GNT;
          end
        end
      end
      WAIT_GNT: begin
        if (imem_gnt)   next_state = flush ? DROP : WAIT_RESP;
        else if (flush) next_state = IDLE;
      end
      WAIT_RESP: begin
        if (imem_rvalid) begin
          next_state = IDLE;
          push       = !flush;
        end else if (flush) begin
          next_state = DROP;
        end
      end
      DROP: begin
        if (imem_rvalid) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      fetch_pc  <= '0;
    end else begin
      state    <= next_state;
      imem_req <= (next_state == WAIT_GNT);
      if (issue) begin
        imem_addr <= {pc_in[XLEN-1:2], 2'b00};
        fetch_pc  <= pc_in;
      end
    end
  end

  assign pc_advance = imem_req && imem_gnt && !flush;

  fetch_queue #(
    .DEPTH (QDEPTH),
    .WIDTH ($bits(entry_t))
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (push_entry),
    .pop       (if_valid && if_ready),
    .head      (head),
    .count     (count)
  );

  assign if_valid = (count != '0);
  assign if_pc    = head.pc;
  assign if_instr = head.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// against a transaction-level model (PC register, memory and expected queue).
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int QDEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_advance;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        if_fault;
`endif

  fetch_unit #(.QDEPTH(QDEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_in       (pc_in),
    .pc_advance  (pc_advance),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_ready    (if_ready)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .if_fault  (if_fault)
`endif
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // Model: transaction flags instead of FSM states, plus the expected queue.
  entry_t      exp_q[$];
  bit          req_out;
  bit          resp_owed;
  bit          wanted;
  bit          stalled_m;
  logic [31:0] issued_pc;
  logic [31:0] pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic [31:0] start_pc);
    rst = 1'b1; flush = 1'b0; if_ready = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; pc_in = start_pc;
    #1;
    check("rst_imem_req", imem_req, 0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_if_valid", if_valid, 0);
    check("rst_if_instr", if_instr, 0);
    check("rst_if_pc", if_pc, 0);
    check("rst_pc_advance", pc_advance, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("rst_if_fault", if_fault, 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    req_out = 0; resp_owed = 0; wanted = 0; stalled_m = 0;
    issued_pc = '0;
    pc = start_pc;
  endtask

  // One clock cycle: apply inputs, check outputs against the model, advance the model.
  task automatic tick(input logic fl, input logic [31:0] redir, input logic rdy,
                      input logic gnt, input logic rv, input logic [31:0] rd);
    logic adv;
    bit   idle0;
    int   size0;
    flush = fl; if_ready = rdy; imem_gnt = gnt; imem_rvalid = rv; imem_rdata = rd; pc_in = pc;
    #1;
    adv = req_out && gnt && !fl;
    check("imem_req", imem_req, req_out);
    if (req_out) check("imem_addr", imem_addr, {issued_pc[31:2], 2'b00});
    check("pc_advance", pc_advance, adv);
    check("if_valid", if_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check("if_pc", if_pc, exp_q[0].pc);
      check("if_instr", if_instr, exp_q[0].instr);
`ifdef FETCH_MISALIGN_TRAP_EN
      check("if_fault", if_fault, exp_q[0].fault);
`endif
    end

    idle0 = !req_out && !resp_owed;
    size0 = exp_q.size();
    if (fl) exp_q.delete();
    else begin
      if (size0 != 0 && rdy) void'(exp_q.pop_front());
      if (resp_owed && rv && wanted) exp_q.push_back('{pc: issued_pc, instr: rd, fault: 1'b0});
    end
    if (resp_owed) begin
      if (rv)      resp_owed = 0;
      else if (fl) wanted = 0;
    end
    if (req_out) begin
      if (gnt) begin
        req_out = 0; resp_owed = 1; wanted = !fl;
      end else if (fl) begin
        req_out = 0;
      end
    end else if (idle0 && !fl && !stalled_m && size0 < QDEPTH) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      if (pc[1:0] != 2'b00) begin
        exp_q.push_back('{pc: pc, instr: NOP_INSTR, fault: 1'b1});
        stalled_m = 1;
      end else begin
        req_out = 1; issued_pc = pc;
      end
`else
      req_out = 1; issued_pc = pc;
`endif
    end
    if (fl) stalled_m = 0;
    pc = fl ? redir : (adv ? pc + 32'd4 : pc);
    @(posedge clk); #1;
  endtask

  // Memory that grants immediately and answers one cycle after the grant.
  task automatic auto_tick(input logic fl, input logic [31:0] redir, input logic rdy);
    tick(fl, redir, rdy, req_out, resp_owed, $urandom);
  endtask

  initial begin
    // Minimum latency: request at 1, grant at 1, response at 2, if_valid at 3.
    do_reset(32'h0);
    tick(0, 0, 1, 0, 0, 0);
    tick(0, 0, 1, 1, 0, 0);
    tick(0, 0, 1, 0, 1, 32'h20080005);
    check("lat_if_valid", if_valid, 1);
    check("lat_if_pc", if_pc, 32'h0);
    check("lat_if_instr", if_instr, 32'h20080005);
    tick(0, 0, 1, 0, 0, 0);

    // Queue fills at QDEPTH with decode stalled; order preserved after a pop.
    do_reset(32'h0);
    for (int i = 0; i < 12; i++) auto_tick(0, 0, 0);
    check("full_no_req", imem_req, 0);
    check("full_head_pc", if_pc, 32'h0);
    auto_tick(0, 0, 1);
    check("pop_head_pc", if_pc, 32'h4);
    for (int i = 0; i < 4; i++) auto_tick(0, 0, 0);

    // Grant held off for 4 cycles.
    do_reset(32'h100);
    tick(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 1, 0, 0, 0);
      check("gnt_wait_req", imem_req, 1);
      check("gnt_wait_addr", imem_addr, 32'h100);
    end
    tick(0, 0, 1, 1, 0, 0);
    tick(0, 0, 1, 0, 1, 32'h13);

    // Flush while waiting for the response; late data dropped, redirect fetched.
    do_reset(32'h200);
    tick(0, 0, 1, 0, 0, 0);
    tick(0, 0, 1, 1, 0, 0);
    tick(1, 32'h40, 1, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 0);
    tick(0, 0, 1, 0, 1, 32'hDEADBEEF);
    check("drop_empty", if_valid, 0);
    tick(0, 0, 1, 0, 0, 0);
    check("redir_req", imem_req, 1);
    check("redir_addr", imem_addr, 32'h40);

    // Flush coincident with rvalid and if_ready on a reserved-full queue.
    do_reset(32'h0);
    for (int i = 0; i < 5; i++) auto_tick(0, 0, 0);
    tick(1, 32'h80, 1, 0, 1, 32'h55);
    check("flush_rv_empty", if_valid, 0);
    tick(0, 0, 1, 0, 0, 0);
    // Flush with decode ready while the queue holds QDEPTH entries.
    do_reset(32'h0);
    for (int i = 0; i < 9; i++) auto_tick(0, 0, 0);
    check("full_valid", if_valid, 1);
    tick(1, 32'h300, 1, 0, 0, 0);
    check("flush_full_empty", if_valid, 0);

    // Reset mid-transaction: a stale response after release is ignored.
    tick(0, 0, 1, 0, 0, 0);
    tick(0, 0, 1, 1, 0, 0);
    do_reset(32'h400);
    tick(0, 0, 1, 0, 1, 32'hBAD0BAD0);
    check("stale_resp_ignored", if_valid, 0);

`ifdef FETCH_MISALIGN_TRAP_EN
    // Misaligned PC: fault entry, no request, stall until flush.
    do_reset(32'h6);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0, 0);
    check("trap_no_req", imem_req, 0);
    check("trap_fault", if_fault, 1);
    check("trap_pc", if_pc, 32'h6);
    tick(1, 32'h10, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    check("trap_resume_req", imem_req, 1);
    check("trap_resume_addr", imem_addr, 32'h10);
`endif

    // Randomized traffic: variable grant/response latency, decode backpressure, flushes.
    do_reset(32'h1000);
    for (int i = 0; i < 1500; i++) begin
      logic fl;
      fl = ($urandom_range(0, 15) == 0);
      tick(fl, {$urandom_range(0, 32'h3FFF), 2'b00}, ($urandom_range(0, 3) != 0),
           req_out && ($urandom_range(0, 2) != 0),
           resp_owed && ($urandom_range(0, 1) != 0), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
